rsnn_config_loader: RTL and testbench

- Byte-stream configuration writer for the three-layer RSNN core. Drives the core's `input_weights[215:0]` and `neuron_params[95:0]` buses from a narrow 8-bit valid/ready stream, such as the TinyTapeout pins.
- Config is double-buffered. Bytes go into a shadow register; a checksum-verified frame commits the shadow to the active outputs in one atomic cycle, so the network never sees a half-written config.

---
 rtl/rsnn_cfg_pkg.sv | 11 +
 rtl/rsnn_cfg_watchdog.sv | 21 ++
 rtl/rsnn_config_loader.sv | 141 ++++++++++++++
 tb/tb_rsnn_config_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsnn_cfg_pkg.sv
// rsnn_cfg_pkg: shared states, error codes and sizing helpers for the RSNN config loader.
package rsnn_cfg_pkg;
  typedef enum logic [2:0] {IDLE, START, COUNT, DATA, CHECK, COMMIT} state_e;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  function automatic int total_bytes(input int weight_bits, input int param_bits);
    return (weight_bits + param_bits) / 8;
  endfunction
endpackage

// File: rtl/rsnn_cfg_watchdog.sv
// rsnn_cfg_watchdog: idle-cycle counter that aborts a stalled frame (used under RSNN_CFG_FRAME_TIMEOUT_EN).
module rsnn_cfg_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic xfer,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic idle;
  assign idle = active && !xfer;
  // Fires on the idle cycle whose edge would bring the count to the limit.
  assign expired = idle && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb cnt_d = idle ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rsnn_config_loader.sv
// rsnn_config_loader: byte-stream, checksum-verified, double-buffered config writer for the RSNN core.
// Optional frame idle timeout enabled by defining RSNN_CFG_FRAME_TIMEOUT_EN.
module rsnn_config_loader
  import rsnn_cfg_pkg::*;
#(
  parameter int NUM_WEIGHT_BITS = 216,
  parameter int NUM_PARAM_BITS = 96,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_WEIGHT_BITS-1:0] input_weights,
  output logic [NUM_PARAM_BITS-1:0]  neuron_params,
  output logic                       cfg_valid,
  output logic                       commit_pulse,
  output logic                       err_pulse,
  output logic [1:0]                 err_code
);
  localparam int NBYTES = total_bytes(NUM_WEIGHT_BITS, NUM_PARAM_BITS);
  localparam int NB = NBYTES * 8;
  localparam logic [8:0] LIMIT = 9'(NBYTES);
  state_e state_q, state_d;
  logic [7:0] ptr_q, ptr_d, rem_q, rem_d, xor_q, xor_d;
  logic match_q, match_d;
  logic [NB-1:0] shadow_q, shadow_d, active_q, active_d;
  logic cfg_valid_q, cfg_valid_d, commit_q, commit_d, err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic xfer, in_frame, timeout, range_ok;
  assign in_ready = state_q != COMMIT;
  assign xfer = in_valid && in_ready;
  assign in_frame = state_q inside {START, COUNT, DATA, CHECK};
  // ptr_q holds START while in COUNT; 9-bit sum so START+COUNT cannot wrap.
  assign range_ok = ({1'b0, ptr_q} < LIMIT) && (in_data != 8'd0) &&
                    (({1'b0, ptr_q} + {1'b0, in_data}) <= LIMIT);
`ifdef RSNN_CFG_FRAME_TIMEOUT_EN
  rsnn_cfg_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .active(in_frame),
    .xfer(xfer),
    .expired(timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = in_frame ^ TIMEOUT_CYCLES[0];
  assign timeout = 1'b0;
`endif
  assign input_weights = active_q[NUM_WEIGHT_BITS-1:0];
  assign neuron_params = active_q[NB-1:NUM_WEIGHT_BITS];
  assign cfg_valid = cfg_valid_q;
  assign commit_pulse = commit_q;
  assign err_pulse = err_q;
  assign err_code = err_code_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    xor_d = xor_q;
    match_d = match_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cfg_valid_d = cfg_valid_q;
    commit_d = 1'b0;
    err_d = 1'b0;
    err_code_d = err_code_q;
    if (timeout) begin
      shadow_d = active_q;
      err_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d = IDLE;
    end else if (state_q == COMMIT) begin
      // A rejected frame restores the shadow so stale bytes never leak into a later commit.
      active_d = match_q ? shadow_q : active_q;
      shadow_d = match_q ? shadow_q : active_q;
      commit_d = match_q;
      cfg_valid_d = cfg_valid_q | match_q;
      err_d = !match_q;
      err_code_d = match_q ? err_code_q : ERR_CHK;
      state_d = IDLE;
    end else if (xfer) begin
      case (state_q)
        IDLE: state_d = (in_data == SYNC_BYTE) ? START : IDLE;
        START: begin
          ptr_d = in_data;
          xor_d = in_data;
          state_d = COUNT;
        end
        COUNT: begin
          xor_d = xor_q ^ in_data;
          rem_d = in_data;
          err_d = !range_ok;
          err_code_d = range_ok ? err_code_q : ERR_RANGE;
          state_d = range_ok ? DATA : IDLE;
        end
        DATA: begin
          for (int i = 0; i < NBYTES; i++)
            if (ptr_q == 8'(i)) shadow_d[i*8 +: 8] = in_data;
          ptr_d = ptr_q + 8'd1;
          rem_d = rem_q - 8'd1;
          xor_d = xor_q ^ in_data;
          state_d = (rem_q == 8'd1) ? CHECK : DATA;
        end
        CHECK: begin
          match_d = xor_q == in_data;
          state_d = COMMIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      rem_q <= '0;
      xor_q <= '0;
      match_q <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      cfg_valid_q <= 1'b0;
      commit_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      xor_q <= xor_d;
      match_q <= match_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cfg_valid_q <= cfg_valid_d;
      commit_q <= commit_d;
      err_q <= err_d;
      err_code_q <= err_code_d;
    end
endmodule

// File: tb/tb_rsnn_config_loader.sv
// tb_rsnn_config_loader: randomized self-checking bench against a byte-array model of the active config.
module tb_rsnn_config_loader;
  localparam int NBYTES = 39;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic in_valid = 1'b0;
  logic in_ready, cfg_valid, commit_pulse, err_pulse;
  logic [215:0] input_weights;
  logic [95:0] neuron_params;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  logic [7:0] act_m [NBYTES];
  bit cfg_m;
  logic [1:0] code_m;
  logic [7:0] dq [$];
  logic obs_rdy, obs_commit, obs_err, obs_after;
  logic [1:0] obs_code;

  rsnn_config_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .input_weights(input_weights),
    .neuron_params(neuron_params),
    .cfg_valid(cfg_valid),
    .commit_pulse(commit_pulse),
    .err_pulse(err_pulse),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, required end before 500000");
    $fatal(1);
  end

  function automatic logic [311:0] vec_m();
    logic [311:0] v;
    for (int i = 0; i < NBYTES; i++) v[i*8 +: 8] = act_m[i];
    return v;
  endfunction

  function automatic logic [7:0] calc_chk(input int s, input int c);
    logic [7:0] x;
    x = s[7:0] ^ c[7:0];
    foreach (dq[i]) x ^= dq[i];
    return x;
  endfunction

  // Frame outcome from the protocol rules: range check, then checksum, then byte placement.
  function automatic void model_frame(input int s, input int c, input logic [7:0] chk,
                                      output bit rng, output bit ok);
    rng = (s <= NBYTES - 1) && (c >= 1) && (s + c <= NBYTES);
    ok = rng && (calc_chk(s, c) == chk);
    if (ok) begin
      foreach (dq[i]) act_m[s + i] = dq[i];
      cfg_m = 1'b1;
    end else code_m = rng ? 2'd2 : 2'd1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 8) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int s, input int c, input logic [7:0] chk, input bit hdr_only, input int gmax);
    send_byte(8'hA5, $urandom_range(gmax, 0));
    send_byte(s[7:0], $urandom_range(gmax, 0));
    send_byte(c[7:0], $urandom_range(gmax, 0));
    if (hdr_only) begin
      obs_err = err_pulse; obs_code = err_code; obs_commit = commit_pulse;
      foreach (dq[i]) send_byte(dq[i], 0);
    end else begin
      foreach (dq[i]) send_byte(dq[i], $urandom_range(gmax, 0));
      send_byte(chk, $urandom_range(gmax, 0));
      obs_rdy = in_ready;
      @(posedge clk); #1;
      obs_commit = commit_pulse; obs_err = err_pulse; obs_code = err_code;
      @(posedge clk); #1;
      obs_after = commit_pulse | err_pulse;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NBYTES; i++) act_m[i] = 8'h00;
    cfg_m = 1'b0; code_m = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if ({neuron_params, input_weights} !== 312'd0) begin errors++; $display("FAIL reset_outputs: got %h required 0", {neuron_params, input_weights}); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid: got %b required 0", cfg_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if ({commit_pulse, err_pulse, err_code} !== 4'd0) begin errors++; $display("FAIL reset_pulses: got %b required 0000", {commit_pulse, err_pulse, err_code}); end
  endtask

  task automatic test_full_load();
    bit rng, ok;
    dq = {};
    for (int i = 0; i < NBYTES; i++) dq.push_back(8'(i));
    model_frame(0, 39, 8'h00, rng, ok);
    send_frame(0, 39, 8'h00, 1'b0, 0);
    checks++; if (input_weights[15:0] !== 16'h0100) begin errors++; $display("FAIL full_weights_lo: got %h required 0100", input_weights[15:0]); end
    checks++; if (neuron_params[7:0] !== 8'h1B) begin errors++; $display("FAIL full_params_lo: got %h required 1b", neuron_params[7:0]); end
    checks++; if (neuron_params[95:88] !== 8'h26) begin errors++; $display("FAIL full_params_hi: got %h required 26", neuron_params[95:88]); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL full_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
    checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL full_commit_ready: got %b required 0", obs_rdy); end
    checks++; if ({obs_commit, obs_after} !== 2'b10) begin errors++; $display("FAIL full_commit_pulse: got %b required 10", {obs_commit, obs_after}); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL full_cfg_valid: got %b required 1", cfg_valid); end
  endtask

  task automatic test_partial();
    bit rng, ok;
    dq = {8'hAA, 8'hBB};
    model_frame(27, 2, 8'h08, rng, ok);
    send_frame(27, 2, 8'h08, 1'b0, 0);
    checks++; if (neuron_params[15:0] !== 16'hBBAA) begin errors++; $display("FAIL partial_params: got %h required bbaa", neuron_params[15:0]); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL partial_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask

  task automatic test_bad_checksum();
    bit rng, ok;
    dq = {8'h11, 8'h22};
    model_frame(27, 2, 8'h00, rng, ok);
    send_frame(27, 2, 8'h00, 1'b0, 0);
    checks++; if ({obs_err, obs_commit, obs_after} !== 3'b100) begin errors++; $display("FAIL badchk_pulses: got %b required 100", {obs_err, obs_commit, obs_after}); end
    checks++; if (obs_code !== 2'd2) begin errors++; $display("FAIL badchk_code: got %0d required 2", obs_code); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL badchk_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
    dq = {8'h5C};
    model_frame(0, 1, 8'h5D, rng, ok);
    send_frame(0, 1, 8'h5D, 1'b0, 0);
    checks++; if (input_weights[7:0] !== 8'h5C) begin errors++; $display("FAIL restore_weight: got %h required 5c", input_weights[7:0]); end
    checks++; if (neuron_params[15:0] !== 16'hBBAA) begin errors++; $display("FAIL restore_params: got %h required bbaa", neuron_params[15:0]); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL restore_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask

  task automatic test_range();
    bit rng, ok;
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    dq = {8'h11};
    model_frame(38, 2, 8'h00, rng, ok);
    send_frame(38, 2, 8'h00, 1'b1, 0);
    checks++; if ({obs_err, obs_commit} !== 2'b10) begin errors++; $display("FAIL range_pulse: got %b required 10", {obs_err, obs_commit}); end
    checks++; if (obs_code !== 2'd1) begin errors++; $display("FAIL range_code: got %0d required 1", obs_code); end
    repeat (2) @(posedge clk); #1;
    checks++; if (err_code !== code_m) begin errors++; $display("FAIL range_code_held: got %0d required %0d", err_code, code_m); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL range_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask

  task automatic test_back_to_back();
    bit rng, ok;
    dq = {8'h77};
    model_frame(5, 1, 8'h73, rng, ok);
    send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h77, 0);
    in_data = 8'h73; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'hA5;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_commit: got %b required 0", in_ready); end
    @(posedge clk); #1;
    checks++; if ({commit_pulse, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_after_commit: got %b required 11", {commit_pulse, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dq = {8'h88};
    model_frame(6, 1, 8'h8F, rng, ok);
    send_byte(8'h06, 0); send_byte(8'h01, 0); send_byte(8'h88, 0); send_byte(8'h8F, 0);
    @(posedge clk); #1;
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL b2b_second_commit: got %b required 1", commit_pulse); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL b2b_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask

  task automatic test_random();
    bit rng, ok;
    int s, c;
    logic [7:0] chk;
    for (int it = 0; it < 30; it++) begin
      dq = {};
      if (it % 5 == 4) begin
        do begin s = $urandom_range(80, 0); c = $urandom_range(80, 0); end
        while (s <= NBYTES - 1 && c >= 1 && s + c <= NBYTES);
        model_frame(s, c, 8'h00, rng, ok);
        send_frame(s, c, 8'h00, 1'b1, 2);
        checks++; if ({obs_err, obs_code} !== 3'b101) begin errors++; $display("FAIL rand_range_%0d: got err=%b code=%0d required err=1 code=1", it, obs_err, obs_code); end
      end else begin
        s = $urandom_range(NBYTES - 1, 0);
        c = $urandom_range(NBYTES - s, 1);
        for (int i = 0; i < c; i++) dq.push_back(8'($urandom_range(255, 0)));
        chk = calc_chk(s, c);
        if ($urandom_range(3, 0) == 0) chk ^= 8'($urandom_range(255, 1));
        model_frame(s, c, chk, rng, ok);
        send_frame(s, c, chk, 1'b0, 2);
        checks++; if ({obs_commit, obs_err, obs_after} !== {ok, !ok, 1'b0}) begin errors++; $display("FAIL rand_pulses_%0d: got %b required %b", it, {obs_commit, obs_err, obs_after}, {ok, !ok, 1'b0}); end
      end
      checks++; if ({cfg_valid, err_code} !== {cfg_m, code_m}) begin errors++; $display("FAIL rand_status_%0d: got %b required %b", it, {cfg_valid, err_code}, {cfg_m, code_m}); end
      checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL rand_vec_%0d: got %h required %h", it, {neuron_params, input_weights}, vec_m()); end
    end
  endtask

`ifdef RSNN_CFG_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    bit rng, ok;
    int n;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h01, 0);
    n = 0;
    while (!err_pulse && n < 30) begin @(posedge clk); #1; n++; end
    code_m = 2'd3;
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_cycles: got %0d required 8", n); end
    checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL timeout_code: got %0d required 3", err_code); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL timeout_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
    dq = {8'h99};
    model_frame(1, 1, 8'h99, rng, ok);
    send_frame(1, 1, 8'h99, 1'b0, 0);
    checks++; if (obs_commit !== 1'b1) begin errors++; $display("FAIL timeout_fresh_commit: got %b required 1", obs_commit); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL timeout_fresh_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask
`else
  task automatic test_timeout();
    bit rng, ok, seen;
    dq = {8'h01, 8'h02, 8'h03};
    model_frame(0, 3, 8'h03, rng, ok);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h01, 0);
    seen = 1'b0;
    repeat (300) begin @(posedge clk); #1; seen |= err_pulse; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stall_no_error: got %b required 0", seen); end
    send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h03, 0);
    @(posedge clk); #1;
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL stall_commit: got %b required 1", commit_pulse); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL stall_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask
`endif

  task automatic test_reset_mid_data();
    bit rng, ok;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h05, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NBYTES; i++) act_m[i] = 8'h00;
    cfg_m = 1'b0; code_m = 2'd0;
    checks++; if ({neuron_params, input_weights} !== 312'd0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", {neuron_params, input_weights}); end
    checks++; if ({cfg_valid, in_ready, err_code} !== 4'b0100) begin errors++; $display("FAIL midreset_status: got %b required 0100", {cfg_valid, in_ready, err_code}); end
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h33, 0);
    checks++; if ({cfg_valid, err_pulse, commit_pulse} !== 3'b000) begin errors++; $display("FAIL midreset_idle_drop: got %b required 000", {cfg_valid, err_pulse, commit_pulse}); end
    dq = {8'h44};
    model_frame(0, 1, 8'h45, rng, ok);
    send_frame(0, 1, 8'h45, 1'b0, 0);
    checks++; if ({obs_commit, cfg_valid} !== 2'b11) begin errors++; $display("FAIL midreset_fresh_commit: got %b required 11", {obs_commit, cfg_valid}); end
    checks++; if ({neuron_params, input_weights} !== vec_m()) begin errors++; $display("FAIL midreset_vec: got %h required %h", {neuron_params, input_weights}, vec_m()); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_partial();
    test_bad_checksum();
    test_range();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
